pagesel_mmu: RTL and testbench

- Parametrised successor to the single-page selector. Provides NWIN independent bank-window page registers with staged writes, delayed commit, per-window write protect, and a DEPTH-entry hardware stack that saves and restores the page map across interrupts.
- Sits on the CPU I/O bus as a small register block. Drives the address-decode/bank logic and the built-in RAM disable.

---
 rtl/pagesel_mmu.sv | 182 ++++++++++++++++++
 tb/tb_pagesel_mmu.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pagesel_mmu.sv
// Bank-window page selector: NWIN staged/active page registers with delayed commit,
// per-window write protect and a DEPTH-entry context stack for interrupt entry/return.
module pagesel_mmu #(
  parameter int NWIN      = 4,
  parameter int PAGE_BITS = 5,
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         AD,
  input  logic [7:0]                DI,
  output logic [7:0]                DO,
  input  logic                      rw,
  input  logic                      cs,
  input  logic                      vma,
  input  logic                      irq_entry,
  input  logic                      rti,
  output logic [NWIN*PAGE_BITS-1:0] page,
  output logic [NWIN-1:0]           wp,
  output logic                      bram_disable
);

  localparam int MW = NWIN * PAGE_BITS;
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(NWIN);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(NWIN + 1);
  localparam logic [ADDR_W-1:0] A_WPM  = ADDR_W'(NWIN + 2);

  logic [PAGE_BITS-1:0] r_stage  [NWIN];
  logic [PAGE_BITS-1:0] r_active [NWIN];
  logic [MW-1:0]        r_stack  [8];
  logic [3:0]           r_depth;
  logic                 r_ovf, r_unf, r_pending, r_lock, r_bram;
  logic [2:0]           r_cnt, r_delay;
  logic [NWIN-1:0]      r_wp_mask;
  logic [7:0]           r_do;

  logic [PAGE_BITS-1:0] w_stage_n  [NWIN];
  logic [PAGE_BITS-1:0] w_active_n [NWIN];
  logic [3:0]           w_depth_n;
  logic                 w_ovf_n, w_unf_n, w_pending_n, w_lock_n, w_bram_n;
  logic [2:0]           w_cnt_n, w_delay_n;
  logic [NWIN-1:0]      w_wp_mask_n;
  logic [7:0]           w_rd_data;
  logic                 w_wr, w_rd, w_commit, w_push, w_pop, w_push_ok;
  logic [2:0]           w_push_idx, w_pop_idx;
  logic [MW-1:0]        w_pop_map;

  // One register access per cycle with cs high; irq_entry masks a simultaneous rti.
  assign w_wr       = cs & ~rw;
  assign w_rd       = cs & rw;
  assign w_commit   = w_wr && (AD == A_CTRL) && DI[7];
  assign w_push     = irq_entry;
  assign w_pop      = rti & ~irq_entry;
  assign w_push_ok  = w_push && (r_depth < 4'(DEPTH));
  assign w_push_idx = r_depth[2:0];
  assign w_pop_idx  = 3'(r_depth - 4'd1);
  assign w_pop_map  = r_stack[w_pop_idx];

  always_comb begin
    w_stage_n   = r_stage;
    w_active_n  = r_active;
    w_depth_n   = r_depth;
    w_ovf_n     = r_ovf;
    w_unf_n     = r_unf;
    w_pending_n = r_pending;
    w_cnt_n     = r_cnt;
    w_delay_n   = r_delay;
    w_lock_n    = r_lock;
    w_bram_n    = r_bram;
    w_wp_mask_n = r_wp_mask;

    if (w_wr && (AD == A_STAT)) begin
      if (DI[7]) w_ovf_n = 1'b0;
      if (DI[6]) w_unf_n = 1'b0;
    end

    if (w_commit) begin
      if (DI[6:4] == 3'd0) begin
        w_active_n  = r_stage;
        w_pending_n = 1'b0;
        w_cnt_n     = 3'd0;
      end else begin
        w_pending_n = 1'b1;
        w_cnt_n     = DI[6:4];
      end
    end else if (r_pending && vma) begin
      if (r_cnt == 3'd1) begin
        w_active_n  = r_stage;
        w_pending_n = 1'b0;
        w_cnt_n     = 3'd0;
      end else begin
        w_cnt_n = r_cnt - 3'd1;
      end
    end

    // Pop overrides any commit outcome computed above.
    if (w_push) begin
      if (w_push_ok) w_depth_n = r_depth + 4'd1;
      else           w_ovf_n   = 1'b1;
    end else if (w_pop) begin
      if (r_depth != 4'd0) begin
        w_depth_n = r_depth - 4'd1;
        for (int i = 0; i < NWIN; i++) begin
          w_active_n[i] = w_pop_map[i*PAGE_BITS +: PAGE_BITS];
          w_stage_n[i]  = w_pop_map[i*PAGE_BITS +: PAGE_BITS];
        end
        w_pending_n = 1'b0;
        w_cnt_n     = 3'd0;
      end else begin
        w_unf_n = 1'b1;
      end
    end

    // Register writes land after a pop restore so a same-cycle STAGE write wins.
    if (w_wr) begin
      for (int i = 0; i < NWIN; i++) begin
        if (AD == ADDR_W'(i)) w_stage_n[i] = DI[PAGE_BITS-1:0];
      end
      if (AD == A_CTRL) begin
        w_bram_n  = DI[0];
        w_lock_n  = DI[1];
        w_delay_n = DI[6:4];
      end
      if (AD == A_WPM) w_wp_mask_n = DI[NWIN-1:0];
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NWIN; i++) begin
      if (AD == ADDR_W'(i)) w_rd_data[PAGE_BITS-1:0] = r_stage[i];
    end
    if (AD == A_CTRL) w_rd_data = {1'b0, r_delay, 2'b00, r_lock, r_bram};
    if (AD == A_STAT) w_rd_data = {r_ovf, r_unf, r_pending, 1'b0, r_depth};
    if (AD == A_WPM)  w_rd_data[NWIN-1:0] = r_wp_mask;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NWIN; i++) begin
        r_stage[i]  <= '0;
        r_active[i] <= '0;
      end
      for (int i = 0; i < 8; i++) r_stack[i] <= '0;
      r_depth   <= 4'd0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_pending <= 1'b0;
      r_cnt     <= 3'd0;
      r_delay   <= 3'd0;
      r_lock    <= 1'b0;
      r_bram    <= 1'b1;
      r_wp_mask <= '0;
      r_do      <= 8'd0;
    end else begin
      r_stage   <= w_stage_n;
      r_active  <= w_active_n;
      r_depth   <= w_depth_n;
      r_ovf     <= w_ovf_n;
      r_unf     <= w_unf_n;
      r_pending <= w_pending_n;
      r_cnt     <= w_cnt_n;
      r_delay   <= w_delay_n;
      r_lock    <= w_lock_n;
      r_bram    <= w_bram_n;
      r_wp_mask <= w_wp_mask_n;
      if (w_push_ok) r_stack[w_push_idx] <= page;
      if (w_rd)      r_do <= w_rd_data;
    end
  end

  always_comb begin
    page = '0;
    for (int i = 0; i < NWIN; i++) page[i*PAGE_BITS +: PAGE_BITS] = r_active[i];
  end

  assign wp           = r_wp_mask & {NWIN{r_lock}};
  assign bram_disable = r_bram;
  assign DO           = r_do;

endmodule

// File: tb/tb_pagesel_mmu.sv
// Directed bench for pagesel_mmu: a table of bus cycles with hand-computed outputs,
// followed by hand-written sequences for same-cycle collisions and mid-run reset.
module tb_pagesel_mmu;

  logic        clk, rst;
  logic [2:0]  AD;
  logic [7:0]  DI, DO;
  logic        rw, cs, vma, irq_entry, rti;
  logic [19:0] page;
  logic [3:0]  wp;
  logic        bram_disable;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        cs, rw;
    logic [2:0]  ad;
    logic [7:0]  di;
    logic        vma, irq, rti;
    logic        chk_do;
    logic [7:0]  exp_do;
    logic [19:0] exp_page;
    logic [3:0]  exp_wp;
    logic        exp_bram;
    string       name;
  } vec_t;

  vec_t vecs[$];

  pagesel_mmu #(.NWIN(4), .PAGE_BITS(5), .DEPTH(4), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
    .vma(vma), .irq_entry(irq_entry), .rti(rti), .page(page), .wp(wp),
    .bram_disable(bram_disable)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [19:0] pm(input logic [4:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic void add(input logic c, r, input logic [2:0] a, input logic [7:0] d,
                              input logic v, i, t, input logic chk, input logic [7:0] edo,
                              input logic [19:0] ep, input logic [3:0] ew, input logic eb,
                              input string nm);
    vec_t x;
    x.cs = c; x.rw = r; x.ad = a; x.di = d; x.vma = v; x.irq = i; x.rti = t;
    x.chk_do = chk; x.exp_do = edo; x.exp_page = ep; x.exp_wp = ew; x.exp_bram = eb;
    x.name = nm;
    vecs.push_back(x);
  endfunction

  function automatic void wr(input logic [2:0] a, input logic [7:0] d, input logic [19:0] ep,
                             input logic [3:0] ew, input logic eb, input string nm);
    add(1'b1, 1'b0, a, d, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, ep, ew, eb, nm);
  endfunction

  function automatic void rd(input logic [2:0] a, input logic [7:0] edo, input logic [19:0] ep,
                             input logic [3:0] ew, input logic eb, input string nm);
    add(1'b1, 1'b1, a, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, edo, ep, ew, eb, nm);
  endfunction

  function automatic void idle(input logic v, i, t, input logic [19:0] ep,
                               input logic [3:0] ew, input logic eb, input string nm);
    add(1'b0, 1'b1, 3'd0, 8'h00, v, i, t, 1'b0, 8'h00, ep, ew, eb, nm);
  endfunction

  // scoreboard check
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // driver: present one bus cycle at negedge, sample #1 after the rising edge
  task automatic bus(input logic c, r, input logic [2:0] a, input logic [7:0] d,
                     input logic v, i, t);
    @(negedge clk);
    cs = c; rw = r; AD = a; DI = d; vma = v; irq_entry = i; rti = t;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t x);
    bus(x.cs, x.rw, x.ad, x.di, x.vma, x.irq, x.rti);
    check({x.name, "_page"}, 32'(page), 32'(x.exp_page));
    check({x.name, "_wp"}, 32'(wp), 32'(x.exp_wp));
    check({x.name, "_bram"}, 32'(bram_disable), 32'(x.exp_bram));
    if (x.chk_do) check({x.name, "_do"}, 32'(DO), 32'(x.exp_do));
  endtask

  initial begin
    logic [19:0] p0, pa, pb, pc, pd;
    p0 = pm(5'd0, 5'd0, 5'd0, 5'd0);
    pa = pm(5'd0, 5'h13, 5'd0, 5'd0);
    pb = pm(5'd7, 5'h13, 5'd0, 5'd0);
    pc = pm(5'd1, 5'd2, 5'd3, 5'd4);
    pd = pm(5'd5, 5'd6, 5'd7, 5'd8);

    // reset values and immediate commit
    rd(3'd4, 8'h01, p0, 4'h0, 1'b1, "rst_ctrl");
    rd(3'd5, 8'h00, p0, 4'h0, 1'b1, "rst_status");
    wr(3'd1, 8'h13, p0, 4'h0, 1'b1, "stage1_nochange");
    rd(3'd1, 8'h13, p0, 4'h0, 1'b1, "stage1_read");
    wr(3'd4, 8'h80, pa, 4'h0, 1'b0, "commit_imm");
    rd(3'd4, 8'h00, pa, 4'h0, 1'b0, "ctrl_bit7_reads0");
    // delayed commit D=3, counted on vma cycles only
    wr(3'd0, 8'h07, pa, 4'h0, 1'b0, "stage0_w");
    wr(3'd4, 8'hB0, pa, 4'h0, 1'b0, "commit_d3");
    rd(3'd5, 8'h20, pa, 4'h0, 1'b0, "pending_set");
    idle(1'b1, 1'b0, 1'b0, pa, 4'h0, 1'b0, "vma1");
    idle(1'b0, 1'b0, 1'b0, pa, 4'h0, 1'b0, "novma");
    idle(1'b1, 1'b0, 1'b0, pa, 4'h0, 1'b0, "vma2");
    rd(3'd5, 8'h20, pa, 4'h0, 1'b0, "pending_still");
    idle(1'b1, 1'b0, 1'b0, pb, 4'h0, 1'b0, "vma3_copy");
    rd(3'd5, 8'h00, pb, 4'h0, 1'b0, "pending_clr");
    rd(3'd4, 8'h30, pb, 4'h0, 1'b0, "ctrl_d3");
    // stack push / pop round trip
    wr(3'd0, 8'h01, pb, 4'h0, 1'b0, "s0");
    wr(3'd1, 8'h02, pb, 4'h0, 1'b0, "s1");
    wr(3'd2, 8'h03, pb, 4'h0, 1'b0, "s2");
    wr(3'd3, 8'h04, pb, 4'h0, 1'b0, "s3");
    wr(3'd4, 8'h80, pc, 4'h0, 1'b0, "commit_1234");
    idle(1'b0, 1'b1, 1'b0, pc, 4'h0, 1'b0, "push1");
    rd(3'd5, 8'h01, pc, 4'h0, 1'b0, "depth1");
    wr(3'd0, 8'h05, pc, 4'h0, 1'b0, "s0b");
    wr(3'd1, 8'h06, pc, 4'h0, 1'b0, "s1b");
    wr(3'd2, 8'h07, pc, 4'h0, 1'b0, "s2b");
    wr(3'd3, 8'h08, pc, 4'h0, 1'b0, "s3b");
    wr(3'd4, 8'h80, pd, 4'h0, 1'b0, "commit_5678");
    idle(1'b0, 1'b0, 1'b1, pc, 4'h0, 1'b0, "pop_restore");
    rd(3'd5, 8'h00, pc, 4'h0, 1'b0, "depth0");
    rd(3'd0, 8'h01, pc, 4'h0, 1'b0, "stage0_restored");
    rd(3'd3, 8'h04, pc, 4'h0, 1'b0, "stage3_restored");
    // overflow, underflow, flag clear
    for (int i = 0; i < 5; i++) idle(1'b0, 1'b1, 1'b0, pc, 4'h0, 1'b0, "push_ovf");
    rd(3'd5, 8'h84, pc, 4'h0, 1'b0, "ovf_depth4");
    for (int i = 0; i < 4; i++) idle(1'b0, 1'b0, 1'b1, pc, 4'h0, 1'b0, "pop_drain");
    idle(1'b0, 1'b0, 1'b1, pc, 4'h0, 1'b0, "pop_unf");
    rd(3'd5, 8'hC0, pc, 4'h0, 1'b0, "ovf_unf");
    wr(3'd5, 8'hC0, pc, 4'h0, 1'b0, "flag_clr");
    rd(3'd5, 8'h00, pc, 4'h0, 1'b0, "flags_cleared");
    // pop cancels a pending commit
    idle(1'b0, 1'b1, 1'b0, pc, 4'h0, 1'b0, "push_p");
    wr(3'd0, 8'h09, pc, 4'h0, 1'b0, "s0_9");
    wr(3'd4, 8'hA0, pc, 4'h0, 1'b0, "commit_d2");
    rd(3'd5, 8'h21, pc, 4'h0, 1'b0, "pending_d1");
    idle(1'b0, 1'b0, 1'b1, pc, 4'h0, 1'b0, "pop_cancel");
    rd(3'd5, 8'h00, pc, 4'h0, 1'b0, "cancel_status");
    rd(3'd0, 8'h01, pc, 4'h0, 1'b0, "cancel_stage0");
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b0, 1'b0, pc, 4'h0, 1'b0, "vma_nocommit");
    // write protect and unused address
    wr(3'd6, 8'h05, pc, 4'h0, 1'b0, "wpmask_nolock");
    rd(3'd6, 8'h05, pc, 4'h0, 1'b0, "wpmask_read");
    wr(3'd4, 8'h02, pc, 4'h5, 1'b0, "lock_on");
    rd(3'd4, 8'h02, pc, 4'h5, 1'b0, "ctrl_lock");
    rd(3'd7, 8'h00, pc, 4'h5, 1'b0, "unused_rd");
    wr(3'd7, 8'hFF, pc, 4'h5, 1'b0, "unused_wr");
    rd(3'd7, 8'h00, pc, 4'h5, 1'b0, "unused_rd2");
    wr(3'd4, 8'h03, pc, 4'h5, 1'b1, "bram_on");
    // STAGE write in the same cycle as a pop wins for that window
    idle(1'b0, 1'b1, 1'b0, pc, 4'h5, 1'b1, "push_w");
    add(1'b1, 1'b0, 3'd2, 8'h1F, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, pc, 4'h5, 1'b1, "pop_wr");
    rd(3'd2, 8'h1F, pc, 4'h5, 1'b1, "pop_wr_stage2");
    rd(3'd5, 8'h00, pc, 4'h5, 1'b1, "pop_wr_depth");

    cs = 1'b0; rw = 1'b1; AD = 3'd0; DI = 8'h00; vma = 1'b0; irq_entry = 1'b0; rti = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    foreach (vecs[k]) apply(vecs[k]);

    // irq_entry and rti together: push wins
    bus(1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1);
    bus(1'b1, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 1'b0);
    check("irq_rti_depth", 32'(DO), 32'h01);
    check("irq_rti_page", 32'(page), 32'(pc));

    // mid-run reset with a pending commit
    bus(1'b1, 1'b0, 3'd4, 8'hF2, 1'b0, 1'b0, 1'b0);
    bus(1'b1, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 1'b0);
    check("pre_rst_status", 32'(DO), 32'h21);
    check("pre_rst_wp", 32'(wp), 32'h5);
    check("pre_rst_bram", 32'(bram_disable), 32'h0);
    bus(1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_page", 32'(page), 32'h0);
    check("rst_bram", 32'(bram_disable), 32'h1);
    check("rst_wp", 32'(wp), 32'h0);
    check("rst_do", 32'(DO), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    bus(1'b1, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 1'b0);
    check("post_rst_status", 32'(DO), 32'h00);
    bus(1'b1, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 1'b0);
    check("post_rst_ctrl", 32'(DO), 32'h01);
    for (int i = 0; i < 8; i++) bus(1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("post_rst_no_commit", 32'(page), 32'h0);
    bus(1'b1, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("post_rst_stage0", 32'(DO), 32'h00);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
